fence_sequencer: RTL
====================

FENCE_SEQUENCER -- requirements
Module: fence_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter FENCEI_WB, default 1: when 1, FENCE.I writes back the dcache before clearing the icache; when 0, the DFLUSH step is skipped.
Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port fencei_req, input, 1: one-cycle pulse from the pipeline requesting a FENCE.I.
REQ-005 The block SHALL have port sfence_req, input, 1: one-cycle pulse from the pipeline requesting an SFENCE.VMA.
REQ-006 The block SHALL have port dcache_flush, output, 1: dcache write-back/flush command.
REQ-007 The block SHALL have port dflush_done, input, 1: dcache flush complete, level or pulse.
REQ-008 The block SHALL have port icache_clear, output, 1: icache invalidate command.
REQ-009 The block SHALL have port iclear_done, input, 1: icache clear complete.
REQ-010 The block SHALL have ports itlb_fence and dtlb_fence, output, 1 each: TLB fence commands.
REQ-011 The block SHALL have ports itlb_fence_done and dtlb_fence_done, input, 1 each: TLB fence complete.
REQ-012 The block SHALL have port busy, output, 1: high whenever the state is not IDLE or a request is pending.
REQ-013 The block SHALL have port fence_done, output, 1: one-cycle pulse when all accepted work completes.

Function
REQ-014 The block SHALL use states IDLE, DFLUSH, ICLEAR, TLB and DONE, encoded in a registered state variable.
REQ-015 The block SHALL set sticky pending bits pend_i on fencei_req and pend_s on sfence_req in any state; a request pulse in the cycle its bit is cleared SHALL keep the bit set.
REQ-016 In IDLE, when pend_i is set, the next state SHALL be DFLUSH if FENCEI_WB=1, else ICLEAR, and pend_i SHALL clear.
REQ-017 In IDLE, when only pend_s is set, the next state SHALL be TLB and pend_s SHALL clear.
REQ-018 When both pending bits are set, FENCE.I SHALL be serviced first.
REQ-019 In DFLUSH, dcache_flush SHALL be 1; on dflush_done=1 the next state SHALL be ICLEAR.
REQ-020 In ICLEAR, icache_clear SHALL be 1; on iclear_done=1 the next state SHALL be TLB if pend_s=1 (clearing it), else DONE.
REQ-021 On TLB entry, itlb_fence and dtlb_fence SHALL both be 1 and done-seen bits i_seen and d_seen SHALL be 0.
REQ-022 In TLB, each fence output SHALL drop the cycle after its done is sampled and set its seen bit; simultaneous dones SHALL be accepted.
REQ-023 When both seen bits are set (registered or the current-cycle done), the next state SHALL be DONE.
REQ-024 In DONE, fence_done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-025 A request pending on DONE SHALL be accepted from IDLE on the following cycle, with no merging into the completed operation.
REQ-026 A done input asserted in a state that does not expect it SHALL be ignored.
REQ-027 Command outputs SHALL be Moore outputs (state and seen bits only), with no combinational path from a done input to a command output.
REQ-028 Each command SHALL stay asserted until its done is seen, with no timeout.

Reset
REQ-029 While RST=1, the state SHALL be IDLE; pend_i, pend_s, i_seen and d_seen SHALL be 0; every output SHALL be 0.
REQ-030 RST asserted mid-sequence SHALL abandon the operation immediately, with no fence_done and all commands deasserted asynchronously.
REQ-031 After RST deasserts, the first accepted request SHALL be one arriving at or after the first rising CLK edge.

Verification
REQ-032 The bench SHALL check: fencei_req pulse at cycle 0, dflush_done at cycle 3, iclear_done at cycle 5 -> dcache_flush cycles 1-3, icache_clear cycles 4-5, fence_done at cycle 6, busy cycles 0-6.
REQ-033 The bench SHALL check: FENCEI_WB=0 with fencei_req at 0 -> dcache_flush never 1, icache_clear from cycle 1.
REQ-034 The bench SHALL check: fencei_req and sfence_req at the same cycle -> DFLUSH, ICLEAR, TLB, then a single fence_done.
REQ-035 The bench SHALL check: sfence_req with dtlb_fence_done 2 cycles before itlb_fence_done -> dtlb_fence drops first, itlb_fence stays, fence_done the cycle after itlb_fence_done.
REQ-036 The bench SHALL check: sfence_req pulse during DFLUSH of a FENCE.I -> serviced in the same sequence after ICLEAR, with one fence_done.
REQ-037 The bench SHALL check: RST during ICLEAR -> outputs 0 immediately, no fence_done; a new fencei_req after reset runs the full sequence.

Source files
------------

// File: rtl/fence_sequencer_if.sv
// ---------------------------------------------------------------------------
// fence_sequencer_if
//   Groups the request, command and completion signals between the pipeline,
//   the caches/TLBs and the fence sequencer.
//   slave  : seen from the sequencer (takes requests/dones, drives commands)
//   master : seen from the pipeline/cache side (the mirror image)
//   Signals:
//     fencei_req, sfence_req          pipeline request pulses
//     dcache_flush / dflush_done      dcache write-back command / completion
//     icache_clear / iclear_done      icache invalidate command / completion
//     itlb_fence,  itlb_fence_done    ITLB fence command / completion
//     dtlb_fence,  dtlb_fence_done    DTLB fence command / completion
//     busy, fence_done                status back to the pipeline
// ---------------------------------------------------------------------------
interface fence_sequencer_if;
    logic fencei_req;
    logic sfence_req;
    logic dcache_flush;
    logic dflush_done;
    logic icache_clear;
    logic iclear_done;
    logic itlb_fence;
    logic dtlb_fence;
    logic itlb_fence_done;
    logic dtlb_fence_done;
    logic busy;
    logic fence_done;

    modport slave (
        input  fencei_req, sfence_req,
        input  dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done,
        output dcache_flush, icache_clear, itlb_fence, dtlb_fence,
        output busy, fence_done
    );

    modport master (
        output fencei_req, sfence_req,
        output dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done,
        input  dcache_flush, icache_clear, itlb_fence, dtlb_fence,
        input  busy, fence_done
    );
endinterface

// File: rtl/fence_sequencer.sv
// ---------------------------------------------------------------------------
// fence_sequencer
//   Orders the cache/TLB maintenance steps of FENCE.I and SFENCE.VMA:
//   DFLUSH (optional) -> ICLEAR -> TLB -> DONE. Requests are latched into
//   sticky pending bits so they can arrive in any state; a FENCE.I is always
//   serviced before a pending SFENCE.VMA, and an SFENCE.VMA pending when the
//   icache clear completes is folded into the same sequence.
//   Parameters:
//     FENCEI_WB : 1 = write back dcache before icache clear, 0 = skip DFLUSH
//   Ports:
//     CLK  : clock, rising edge
//     RST  : asynchronous active-high reset
//     bus  : fence_sequencer_if.slave (requests, commands, dones, status)
// ---------------------------------------------------------------------------
module fence_sequencer #(
    parameter bit FENCEI_WB = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    fence_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DFLUSH = 3'd1,
        ICLEAR = 3'd2,
        TLB    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   pend_i_q, pend_i_d;
    logic   pend_s_q, pend_s_d;
    logic   i_seen_q, i_seen_d;
    logic   d_seen_q, d_seen_d;
    logic   clr_i, clr_s;
    logic   req_i, req_s;

    // A request arriving this cycle counts as pending so IDLE can start on it
    // without an extra cycle of latency.
    assign req_i = pend_i_q | bus.fencei_req;
    assign req_s = pend_s_q | bus.sfence_req;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            pend_i_q <= 1'b0;
            pend_s_q <= 1'b0;
            i_seen_q <= 1'b0;
            d_seen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_i_q <= pend_i_d;
            pend_s_q <= pend_s_d;
            i_seen_q <= i_seen_d;
            d_seen_q <= d_seen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clr_i    = 1'b0;
        clr_s    = 1'b0;
        i_seen_d = i_seen_q;
        d_seen_d = d_seen_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    clr_i = 1'b1;
                    if (FENCEI_WB) state_d = DFLUSH;
                    else           state_d = ICLEAR;
                end else if (req_s) begin
                    clr_s    = 1'b1;
                    state_d  = TLB;
                    i_seen_d = 1'b0;
                    d_seen_d = 1'b0;
                end
            end
            DFLUSH: begin
                if (bus.dflush_done) state_d = ICLEAR;
            end
            ICLEAR: begin
                if (bus.iclear_done) begin
                    if (req_s) begin
                        clr_s    = 1'b1;
                        state_d  = TLB;
                        i_seen_d = 1'b0;
                        d_seen_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            TLB: begin
                // Dones may come in either order or together; the seen bits
                // remember the earlier one.
                i_seen_d = i_seen_q | bus.itlb_fence_done;
                d_seen_d = d_seen_q | bus.dtlb_fence_done;
                if (i_seen_d && d_seen_d) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // When a pending bit is consumed while a fresh pulse also arrives, only
    // one of the two is consumed and the other remains pending.
    assign pend_i_d = clr_i ? (pend_i_q & bus.fencei_req) : (pend_i_q | bus.fencei_req);
    assign pend_s_d = clr_s ? (pend_s_q & bus.sfence_req) : (pend_s_q | bus.sfence_req);

    // Commands depend on registered state only.
    assign bus.dcache_flush = (state_q == DFLUSH);
    assign bus.icache_clear = (state_q == ICLEAR);
    assign bus.itlb_fence   = (state_q == TLB) && !i_seen_q;
    assign bus.dtlb_fence   = (state_q == TLB) && !d_seen_q;
    assign bus.fence_done   = (state_q == DONE);
    // Busy also covers a request arriving this cycle; forced low in reset.
    assign bus.busy         = !RST && ((state_q != IDLE) || req_i || req_s);

endmodule
